// File: rtl/palette_pkg.sv
// Shared types and helpers for the palette fade controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package palette_pkg;

  localparam int PAL_ENTRIES = 16;
  localparam int LEVEL_MAX   = 16;
  localparam int LEVEL_W     = 5;

  // One palette entry, red in the top byte
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FADE_OUT,
    ST_LOAD,
    ST_FADE_IN
  } state_t;

  // c * level / 16; level 16 is unity gain, so bits [11:4] of the
  // 13-bit product give the channel back unchanged at full brightness
  function automatic logic [7:0] scale_chan(input logic [7:0] c,
                                            input logic [LEVEL_W-1:0] level);
    logic [12:0] prod;
    prod = 13'(c) * 13'(level);
    return prod[11:4];
  endfunction

endpackage

// File: rtl/palette_scale.sv
// Brightness scaler: multiplies each colour channel by level/16.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs continuously.
module palette_scale
  import palette_pkg::*;
(
  input  rgb_t                color,
  input  logic [LEVEL_W-1:0]  level,
  output rgb_t                scaled
);

  // Scale the three channels independently with the same level
  always_comb begin
    scaled   = '0;
    scaled.r = scale_chan(color.r, level);
    scaled.g = scale_chan(color.g, level);
    scaled.b = scale_chan(color.b, level);
  end

endmodule

// File: rtl/palette_fade_ctrl.sv
// Live 16-entry palette with fade-out / reload / fade-in switch sequencing.
// Latency: pixel lookup 1 cycle; switch sequence 2*LEVEL_MAX+18 cycles worst case with ticks every cycle.
// Backpressure: none; switch requests arriving while busy are dropped and must be retried.
module palette_fade_ctrl #(
  parameter int NUM_PAL   = 4,
  parameter int LEVEL_MAX = 16
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_switch_req,
  input  logic [((NUM_PAL > 1) ? $clog2(NUM_PAL) : 1)-1:0] i_switch_id,
  output logic                                     o_busy,
  output logic                                     o_done,
  output logic [((NUM_PAL > 1) ? $clog2(NUM_PAL) : 1)-1:0] o_src_sel,
  output logic [3:0]                               o_src_idx,
  input  logic [23:0]                              i_src_color,
  input  logic                                     i_frame_tick,
  input  logic                                     i_pix_valid,
  input  logic [3:0]                               i_pix_idx,
  output logic                                     o_pix_valid,
  output logic [23:0]                              o_pix_color
);

  import palette_pkg::*;

  localparam int                 ID_W     = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;
  localparam logic [LEVEL_W-1:0] LVL_FULL = LEVEL_W'(LEVEL_MAX);
  localparam logic [3:0]         LAST_IDX = 4'(PAL_ENTRIES - 1);

  state_t              state;
  logic [LEVEL_W-1:0]  level;
  logic [3:0]          load_cnt;
  logic [ID_W-1:0]     sel_id;
  logic                busy;
  logic                done;
  rgb_t                pal [PAL_ENTRIES];

  rgb_t                lut_rgb;
  rgb_t                lut_scaled;
  logic                pix_valid_q;
  rgb_t                pix_color_q;

  // Switch sequencer: owns state, brightness level, load counter, latched
  // id and the palette register file. A reset mid-load wipes the palette so
  // no half-loaded mix of two screens can ever be faded back in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      level    <= '0;
      load_cnt <= '0;
      sel_id   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        pal[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Frame ticks are deliberately ignored here, even in the
          // same cycle as an accepted request
          if (i_switch_req) begin
            sel_id <= i_switch_id;
            state  <= ST_FADE_OUT;
            busy   <= 1'b1;
          end
        end
        ST_FADE_OUT: begin
          // Zero check comes first so an already-black screen moves on
          // without waiting for a frame tick
          if (level == '0) begin
            state <= ST_LOAD;
          end else if (i_frame_tick) begin
            level <= level - 1'b1;
          end
        end
        ST_LOAD: begin
          pal[load_cnt] <= i_src_color;
          if (load_cnt == LAST_IDX) begin
            load_cnt <= '0;
            state    <= ST_FADE_IN;
          end else begin
            load_cnt <= load_cnt + 1'b1;
          end
        end
        ST_FADE_IN: begin
          // busy drops in the same cycle the done pulse is visible
          if (level == LVL_FULL) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (i_frame_tick) begin
            level <= level + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Lookup reads the palette and level as they stand in the request cycle
  assign lut_rgb = pal[i_pix_idx];

  palette_scale u_scale (
    .color  (lut_rgb),
    .level  (level),
    .scaled (lut_scaled)
  );

  // Lookup output register: valid always follows, colour updates on valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_valid_q <= 1'b0;
      pix_color_q <= '0;
    end else begin
      pix_valid_q <= i_pix_valid;
      if (i_pix_valid) begin
        pix_color_q <= lut_scaled;
      end
    end
  end

  // The ROM address must be combinational so the ROM data lands in the
  // same cycle as the write it feeds; the index is parked at 0 outside LOAD
  assign o_src_idx   = (state == ST_LOAD) ? load_cnt : 4'd0;
  assign o_src_sel   = sel_id;
  assign o_busy      = busy;
  assign o_done      = done;
  assign o_pix_valid = pix_valid_q;
  assign o_pix_color = pix_color_q;

endmodule
